// File: rtl/lock_pkg.sv
// Shared definitions for the keypad-lock state manager: state encoding,
// state type and the width helpers used to size the counter outputs.
// Optional build macro: AUTO_RELOCK_EN (timed OPEN relock, see top module).
package lock_pkg;

  localparam logic [2:0] ST_OFF    = 3'b000;
  localparam logic [2:0] ST_ON     = 3'b001;
  localparam logic [2:0] ST_WRONG  = 3'b010;
  localparam logic [2:0] ST_OPEN   = 3'b100;
  localparam logic [2:0] ST_REKEY  = 3'b101;
  localparam logic [2:0] ST_LOCKED = 3'b111;

  typedef enum logic [2:0] {
    S_OFF    = ST_OFF,
    S_ON     = ST_ON,
    S_WRONG  = ST_WRONG,
    S_OPEN   = ST_OPEN,
    S_REKEY  = ST_REKEY,
    S_LOCKED = ST_LOCKED
  } state_t;

  // Bits needed to hold values 0..max_value (never less than one bit).
  function automatic int width_for(input int max_value);
    return (max_value < 1) ? 1 : $clog2(max_value + 1);
  endfunction

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lock_state_manager_p_rise_detect.sv
// Single-bit registered rising-edge detector. The history register resets
// to 1 so a level already high when reset releases is not seen as an edge.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic level_q;

  // Remember last cycle's level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) level_q <= 1'b1;
    else       level_q <= level;
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/lock_state_manager_p.sv
// Keypad door-lock state manager: power / code entry / open / rekey /
// brute-force lockout. The wrong-code count survives power-off so cycling
// power cannot reset the lockout budget; only a served lockout or clear does.
// Optional build macro: AUTO_RELOCK_EN -- OPEN relocks after OPEN_CYCLES
// cycles, reusing the lock_remaining register as the OPEN dwell timer.
//
// state  | meaning
// OFF    | lock unpowered (or just cleared / lockout served)
// ON     | powered, waiting for a code
// WRONG  | powered, at least one wrong code entered
// OPEN   | correct code accepted, door released
// REKEY  | waiting for a valid new code
// LOCKED | too many wrong codes; timed lockout, inputs ignored
module lock_state_manager_p
  import lock_pkg::*;
#(
  parameter int MAX_TRIES   = 3,
  parameter int LOCK_CYCLES = 100,
  parameter int OPEN_CYCLES = 1000
) (
  input  logic                                                  clk,
  input  logic                                                  reset,
  input  logic                                                  power_on,
  input  logic                                                  star_pressed,
  input  logic                                                  rekey_req,
  input  logic                                                  code_ok,
  input  logic                                                  clear,
  output logic [2:0]                                            state,
  output logic [width_for(MAX_TRIES)-1:0]                       fail_count,
  output logic [width_for(max_of(LOCK_CYCLES, OPEN_CYCLES))-1:0] lock_remaining,
  output logic                                                  unlock_pulse,
  output logic                                                  rekey_done
);

  localparam int FCW = width_for(MAX_TRIES);
  localparam int TW  = width_for(max_of(LOCK_CYCLES, OPEN_CYCLES));

  localparam logic [FCW-1:0] MAX_FC    = FCW'(MAX_TRIES);
  localparam logic [TW-1:0]  LOCK_LOAD = TW'(LOCK_CYCLES - 1);
`ifdef AUTO_RELOCK_EN
  localparam logic [TW-1:0]  OPEN_LOAD = TW'(OPEN_CYCLES - 1);
`endif

  state_t         state_q;
  logic           star_rise;
  logic           rekey_rise;
  logic [FCW-1:0] fc_inc;

  rise_detect u_star_rise (
    .clk   (clk),
    .reset (reset),
    .level (star_pressed),
    .rise  (star_rise)
  );

  rise_detect u_rekey_rise (
    .clk   (clk),
    .reset (reset),
    .level (rekey_req),
    .rise  (rekey_rise)
  );

  // fail_count is below MAX_TRIES whenever a wrong code can be counted,
  // so the increment never overflows FCW.
  assign fc_inc = fail_count + FCW'(1);

  assign state = state_q;

  // Main FSM with fail counter, shared lock/open timer and output pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_OFF;
      fail_count     <= '0;
      lock_remaining <= '0;
      unlock_pulse   <= 1'b0;
      rekey_done     <= 1'b0;
    end else begin
      unlock_pulse <= 1'b0;
      rekey_done   <= 1'b0;

      if (clear) begin
        state_q        <= S_OFF;
        fail_count     <= '0;
        lock_remaining <= '0;
      end else begin
        case (state_q)
          S_OFF: begin
            lock_remaining <= '0;
            if (power_on) state_q <= S_ON;
          end

          S_ON, S_WRONG: begin
            lock_remaining <= '0;
            if (!power_on) begin
              state_q <= S_OFF;
            end else if (star_rise) begin
              if (code_ok) begin
                state_q      <= S_OPEN;
                fail_count   <= '0;
                unlock_pulse <= 1'b1;
`ifdef AUTO_RELOCK_EN
                lock_remaining <= OPEN_LOAD;
`endif
              end else if (fc_inc >= MAX_FC) begin
                state_q        <= S_LOCKED;
                fail_count     <= MAX_FC;
                lock_remaining <= LOCK_LOAD;
              end else begin
                state_q    <= S_WRONG;
                fail_count <= fc_inc;
              end
            end
          end

          S_LOCKED: begin
            if (lock_remaining == '0) begin
              state_q    <= S_OFF;
              fail_count <= '0;
            end else begin
              lock_remaining <= lock_remaining - TW'(1);
            end
          end

          S_OPEN: begin
            if (!power_on) begin
              state_q        <= S_OFF;
              lock_remaining <= '0;
            end else if (rekey_rise) begin
              state_q        <= S_REKEY;
              lock_remaining <= '0;
            end else begin
`ifdef AUTO_RELOCK_EN
              if (lock_remaining == '0) state_q <= S_ON;
              else                      lock_remaining <= lock_remaining - TW'(1);
`else
              lock_remaining <= '0;
`endif
            end
          end

          S_REKEY: begin
            lock_remaining <= '0;
            if (!power_on) begin
              state_q <= S_OFF;
            end else if (star_rise && code_ok) begin
              state_q    <= S_OFF;
              rekey_done <= 1'b1;
            end
          end

          default: begin
            state_q        <= S_OFF;
            lock_remaining <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lock_state_manager_p.sv
// Bench for lock_state_manager_p: directed scenarios plus a random phase,
// every cycle compared against a behavioural model of the lock rules.
module tb_lock_state_manager_p;

  localparam int MAX_T  = 3;
  localparam int LOCK_C = 8;
  localparam int OPEN_C = 5;

  localparam int K_OFF    = 0;
  localparam int K_ON     = 1;
  localparam int K_WRONG  = 2;
  localparam int K_OPEN   = 4;
  localparam int K_REKEY  = 5;
  localparam int K_LOCKED = 7;

  logic       clk = 1'b0;
  logic       reset;
  logic       power_on;
  logic       star_pressed;
  logic       rekey_req;
  logic       code_ok;
  logic       clear;
  logic [2:0] state;
  logic [1:0] fail_count;
  logic [3:0] lock_remaining;
  logic       unlock_pulse;
  logic       rekey_done;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model state
  int m_st, m_fc, m_lr;
  bit m_up, m_rd;
  bit m_star_prev, m_rekey_prev;

  lock_state_manager_p #(
    .MAX_TRIES   (MAX_T),
    .LOCK_CYCLES (LOCK_C),
    .OPEN_CYCLES (OPEN_C)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .power_on       (power_on),
    .star_pressed   (star_pressed),
    .rekey_req      (rekey_req),
    .code_ok        (code_ok),
    .clear          (clear),
    .state          (state),
    .fail_count     (fail_count),
    .lock_remaining (lock_remaining),
    .unlock_pulse   (unlock_pulse),
    .rekey_done     (rekey_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of the lock rules, applied to the inputs present at the edge.
  task automatic model_tick();
    bit sr, rr;
    sr = star_pressed && !m_star_prev;
    rr = rekey_req && !m_rekey_prev;
    m_star_prev  = star_pressed;
    m_rekey_prev = rekey_req;
    m_up = 0;
    m_rd = 0;
    if (clear) begin
      m_st = K_OFF; m_fc = 0; m_lr = 0;
    end else if (m_st == K_LOCKED) begin
      if (m_lr == 0) begin m_st = K_OFF; m_fc = 0; end
      else m_lr = m_lr - 1;
    end else if (!power_on) begin
      m_st = K_OFF; m_lr = 0;
    end else if (m_st == K_OFF) begin
      m_st = K_ON;
    end else if (m_st == K_ON || m_st == K_WRONG) begin
      if (sr && code_ok) begin
        m_st = K_OPEN; m_fc = 0; m_up = 1;
`ifdef AUTO_RELOCK_EN
        m_lr = OPEN_C - 1;
`else
        m_lr = 0;
`endif
      end else if (sr) begin
        m_fc = m_fc + 1;
        if (m_fc == MAX_T) begin m_st = K_LOCKED; m_lr = LOCK_C - 1; end
        else m_st = K_WRONG;
      end
    end else if (m_st == K_OPEN) begin
      if (rr) begin
        m_st = K_REKEY; m_lr = 0;
      end else begin
`ifdef AUTO_RELOCK_EN
        if (m_lr == 0) m_st = K_ON;
        else m_lr = m_lr - 1;
`endif
      end
    end else if (m_st == K_REKEY) begin
      if (sr && code_ok) begin m_st = K_OFF; m_rd = 1; end
    end
  endtask

  task automatic compare_all();
    chk("state", 32'(state), 32'(m_st));
    chk("fail_count", 32'(fail_count), 32'(m_fc));
    chk("lock_remaining", 32'(lock_remaining), 32'(m_lr));
    chk("unlock_pulse", 32'(unlock_pulse), 32'(m_up));
    chk("rekey_done", 32'(rekey_done), 32'(m_rd));
  endtask

  task automatic step(input bit p, input bit s, input bit r, input bit c, input bit cl);
    @(negedge clk);
    power_on = p; star_pressed = s; rekey_req = r; code_ok = c; clear = cl;
    @(posedge clk);
    model_tick();
    #1;
    compare_all();
  endtask

  // star press then release, power held on
  task automatic press(input bit c);
    step(1, 1, 0, c, 0);
    step(1, 0, 0, c, 0);
  endtask

  initial begin
    reset = 1'b1; power_on = 1'b1; star_pressed = 1'b1;
    rekey_req = 1'b0; code_ok = 1'b0; clear = 1'b0;
    m_st = K_OFF; m_fc = 0; m_lr = 0; m_up = 0; m_rd = 0;
    m_star_prev = 1; m_rekey_prev = 1;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 32'(state), 32'(K_OFF));
    chk("reset_fc", 32'(fail_count), 0);
    chk("reset_lr", 32'(lock_remaining), 0);
    chk("reset_pulses", 32'({unlock_pulse, rekey_done}), 0);

    // release with star held high: ON next cycle, no wrong code counted
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    model_tick();
    #1;
    compare_all();
    chk("rel_on", 32'(state), 32'(K_ON));
    chk("rel_fc", 32'(fail_count), 0);
    step(1, 0, 0, 0, 0);

    // three wrong codes -> WRONG 1, WRONG 2, LOCKED, 8-cycle dwell
    press(0);
    chk("wrong1", 32'(state), 32'(K_WRONG));
    chk("wrong1_fc", 32'(fail_count), 1);
    press(0);
    chk("wrong2_fc", 32'(fail_count), 2);
    step(1, 1, 0, 0, 0);
    chk("lock_enter", 32'(state), 32'(K_LOCKED));
    chk("lock_fc", 32'(fail_count), 3);
    chk("lock_lr7", 32'(lock_remaining), 7);
    for (int k = 6; k >= 0; k--) begin
      step(1, k[0], k[1], 1, 0);
      chk("lock_lr_dec", 32'(lock_remaining), 32'(k));
      chk("lock_hold", 32'(state), 32'(K_LOCKED));
    end
    step(1, 0, 0, 0, 0);
    chk("lock_exit_off", 32'(state), 32'(K_OFF));
    chk("lock_exit_fc", 32'(fail_count), 0);
    step(1, 0, 0, 0, 0);
    chk("off_to_on", 32'(state), 32'(K_ON));

    // fail count survives a power cycle
    press(0);
    press(0);
    step(0, 0, 0, 0, 0);
    chk("pwr_off", 32'(state), 32'(K_OFF));
    chk("pwr_off_fc", 32'(fail_count), 2);
    step(1, 0, 0, 0, 0);
    press(0);
    chk("pwr_cycle_lock", 32'(state), 32'(K_LOCKED));

    // clear mid-lockout at lock_remaining 4
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("pre_clear_lr", 32'(lock_remaining), 4);
    step(1, 0, 0, 0, 1);
    chk("clear_state", 32'(state), 32'(K_OFF));
    chk("clear_fc", 32'(fail_count), 0);
    chk("clear_lr", 32'(lock_remaining), 0);
    step(1, 0, 0, 0, 0);

    // correct code from WRONG(2) -> OPEN, then rekey flow
    press(0);
    press(0);
    step(1, 1, 0, 1, 0);
    chk("open_state", 32'(state), 32'(K_OPEN));
    chk("open_pulse", 32'(unlock_pulse), 1);
    chk("open_fc", 32'(fail_count), 0);
    step(1, 0, 0, 0, 0);
    chk("open_pulse_end", 32'(unlock_pulse), 0);
`ifndef AUTO_RELOCK_EN
    press(0);
    press(1);
    chk("open_star_ignored", 32'(state), 32'(K_OPEN));
    chk("open_lr_zero", 32'(lock_remaining), 0);
`endif
    step(1, 0, 1, 0, 0);
    chk("rekey_enter", 32'(state), 32'(K_REKEY));
    step(1, 0, 0, 0, 0);
    press(0);
    chk("rekey_bad", 32'(state), 32'(K_REKEY));
    chk("rekey_bad_fc", 32'(fail_count), 0);
    step(1, 1, 0, 1, 0);
    chk("rekey_commit", 32'(state), 32'(K_OFF));
    chk("rekey_done", 32'(rekey_done), 1);
    step(1, 0, 0, 0, 0);
    chk("rekey_done_end", 32'(rekey_done), 0);

    // star and rekey together in OPEN: rekey wins
    press(1);
    step(1, 1, 1, 0, 0);
    chk("open_conflict", 32'(state), 32'(K_REKEY));
    step(0, 0, 0, 0, 0);
    chk("rekey_abort", 32'(state), 32'(K_OFF));
    chk("rekey_abort_done", 32'(rekey_done), 0);
    step(1, 0, 0, 0, 0);

    // star with power off: OFF, star not counted
    press(0);
    step(0, 1, 0, 0, 0);
    chk("star_pwroff", 32'(state), 32'(K_OFF));
    chk("star_pwroff_fc", 32'(fail_count), 1);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1);

`ifdef AUTO_RELOCK_EN
    // timed relock after OPEN_C cycles, and rekey before expiry
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 1, 0);
    chk("auto_open_lr", 32'(lock_remaining), 32'(OPEN_C - 1));
    for (int k = 0; k < OPEN_C - 1; k++) step(1, 0, 0, 0, 0);
    chk("auto_still_open", 32'(state), 32'(K_OPEN));
    step(1, 0, 0, 0, 0);
    chk("auto_relock", 32'(state), 32'(K_ON));
    step(1, 1, 0, 1, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0);
    chk("auto_rekey_wins", 32'(state), 32'(K_REKEY));
    for (int k = 0; k < OPEN_C + 2; k++) step(1, 0, 1, 0, 0);
    chk("auto_no_relock", 32'(state), 32'(K_REKEY));
    step(1, 0, 0, 0, 1);
`endif

    // random phase against the model
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 15) != 0),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 63) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lock_state_manager_p.md
Name: lock_state_manager_p

Overview:
Parametrised successor to the keypad-lock state manager.
- Tracks power/entry/open/rekey/lockout for a digital door lock.
- Configurable wrong-try limit and timed lockout that self-releases.
- Failure count survives power-off, so power-cycling cannot defeat brute-force protection.
- Sits between keypad/code-compare logic and display/actuator drivers.

Parameters:
MAX_TRIES, 3, wrong codes accepted before LOCKED (>=1)
LOCK_CYCLES, 100, clk cycles spent in LOCKED (>=1)
OPEN_CYCLES, 1000, clk cycles before OPEN auto-relocks (used only with AUTO_RELOCK_EN)

Ports:
clk  in  1  clock; all logic on posedge
reset  in  1  asynchronous, active-high reset
power_on  in  1  level; 1 = lock powered (# toggle)
star_pressed  in  1  level; internally rising-edge detected
rekey_req  in  1  level; internally rising-edge detected; password-change request
code_ok  in  1  level; sampled on the cycle a star edge is detected
clear  in  1  synchronous initialize; highest functional priority
state  out  3  000 OFF, 001 ON, 010 WRONG, 100 OPEN, 101 REKEY, 111 LOCKED
fail_count  out  FCW  consecutive wrong codes, FCW = $clog2(MAX_TRIES+1)
lock_remaining  out  TW  cycles left in LOCKED, TW = $clog2(max(LOCK_CYCLES,OPEN_CYCLES)+1)
unlock_pulse  out  1  one-cycle pulse on entry to OPEN
rekey_done  out  1  one-cycle pulse on REKEY->OFF commit

Behaviour:
- Reset (async, active-high): state=OFF, fail_count=0, lock_remaining=0, pulses=0. Edge-detect history regs reset to 1, so an input held high at release does not register an edge.
- star_rise = star_pressed & ~star_q; rekey_rise likewise. History regs update every cycle.
- Transition priority per cycle: clear > power_on==0 > star_rise/rekey_rise > timers.
- clear: state=OFF, fail_count=0, lock_remaining=0. Applies in any state, including LOCKED.
- OFF: power_on=1 -> ON next cycle.
- ON/WRONG: power_on=0 -> OFF; fail_count is retained.
- ON/WRONG on star_rise:
  - code_ok=1 -> OPEN, fail_count=0, unlock_pulse=1 for one cycle.
  - code_ok=0 and fail_count+1 < MAX_TRIES -> WRONG, fail_count+1.
  - code_ok=0 and fail_count+1 == MAX_TRIES -> LOCKED, fail_count=MAX_TRIES, lock_remaining=LOCK_CYCLES-1.
- LOCKED:
  - power_on, star and rekey are ignored.
  - lock_remaining decrements once per cycle.
  - On the cycle lock_remaining==0: -> OFF, fail_count=0. Total LOCKED dwell = LOCK_CYCLES cycles.
- OPEN: power_on=0 -> OFF. rekey_rise -> REKEY. star ignored.
- REKEY:
  - star_rise & code_ok (new code valid, >=4 digits) -> OFF, rekey_done pulse.
  - star_rise & ~code_ok -> stay in REKEY, no count change.
  - power_on=0 -> OFF (abort, no rekey_done).
- Same-cycle conflicts: star_rise and rekey_rise together in OPEN -> rekey wins. star_rise with power_on=0 -> OFF, and the star press is not counted.
- lock_remaining reads 0 outside LOCKED.
- Counters saturate; no wrap. fail_count never exceeds MAX_TRIES.
- MAX_TRIES=1: the first wrong code locks immediately; WRONG is never entered.
- Unused encodings (011, 110) -> OFF on the next cycle.

Optional Feature:
AUTO_RELOCK_EN
- Defined: an OPEN dwell counter loads OPEN_CYCLES-1 on entry and reuses the lock_remaining register/output. On reaching 0 in OPEN -> ON, or OFF if power_on=0. rekey_rise before expiry still wins.
- Undefined: OPEN persists until power-off, rekey or clear. OPEN_CYCLES is unused and lock_remaining stays 0 in OPEN.

Decomposition:
- Package lock_pkg:
  - state encoding localparams (ST_OFF, ST_ON, ST_WRONG, ST_OPEN, ST_REKEY, ST_LOCKED), 3-bit;
  - state_t typedef;
  - width helper function for FCW/TW.
- One natural sub-module, rise_detect (1-bit registered edge detector with async reset, history reset to 1), instanced for star and rekey.
- FSM, fail counter and timer stay in the top module.

Test Plan:
- reset released with star_pressed=1, power_on=1 -> ON at cycle 1, no star edge, fail_count=0.
- MAX_TRIES=3, LOCK_CYCLES=8: three wrong stars -> WRONG, fail_count 1, 2, then LOCKED. lock_remaining 7..0, OFF on the 8th cycle, fail_count=0.
- Two wrong stars, power_on=0, power_on=1, one wrong star -> LOCKED (fail_count retained across OFF).
- Correct star from WRONG (fail_count=2) -> OPEN, unlock_pulse high exactly 1 cycle, fail_count=0. rekey_rise -> REKEY. Bad star stays in REKEY. Good star -> OFF with rekey_done 1 cycle.
- clear asserted mid-LOCKED (lock_remaining=4) -> OFF next cycle, all counters 0. Also: star+power_on=0 in the same cycle -> OFF, fail_count unchanged.
- AUTO_RELOCK_EN, OPEN_CYCLES=5: enter OPEN, hold inputs -> ON after 5 cycles. Repeat with rekey_rise at cycle 3 -> REKEY, no relock.
